// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and size codes for the memory access unit
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane store positioning, mask generation and load extraction
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter  int DataWidth = 32,
    localparam int MaskWidth = DataWidth / 8,
    localparam int OffW      = $clog2(MaskWidth)
) (
    input  logic [1:0]           st_size,
    input  logic [OffW-1:0]      st_offset,
    input  logic [DataWidth-1:0] st_data,
    output logic [MaskWidth-1:0] mask,
    output logic [DataWidth-1:0] wdata,
    output logic                 misaligned,
    input  logic [1:0]           ld_size,
    input  logic [OffW-1:0]      ld_offset,
    input  logic                 ld_unsigned,
    input  logic [DataWidth-1:0] rdata,
    output logic [DataWidth-1:0] ld_data
);
    localparam int BitW = $clog2(DataWidth) + 1;

    // Bit mask covering the low 8<<size bits of the bus.
    function automatic logic [DataWidth-1:0] size_keep(input logic [1:0] size);
        logic [BitW-1:0] nbits;
        nbits = BitW'(8) << size;
        return {DataWidth{1'b1}} >> (BitW'(DataWidth) - nbits);
    endfunction

    logic [OffW:0]          st_bytes;
    logic [2*MaskWidth-1:0] st_run;
    logic [DataWidth-1:0]   ld_shifted;
    logic [DataWidth-1:0]   ld_keep;
    logic [DataWidth-1:0]   ld_top;
    logic                   ld_sign;

    // Store side: contiguous byte run at the offset; bytes past the bus edge fall off.
    always_comb begin
        st_bytes   = (OffW+1)'(1) << st_size;
        st_run     = ((2*MaskWidth)'(1) << st_bytes) - (2*MaskWidth)'(1);
        mask       = MaskWidth'(st_run << st_offset);
        misaligned = (st_offset & OffW'(st_bytes - (OffW+1)'(1))) != '0;
        wdata      = (st_data & size_keep(st_size)) << {st_offset, 3'b000};
    end

    // Load side: bring the addressed lanes down to bit 0, then sign- or zero-extend.
    always_comb begin
        ld_shifted = rdata >> {ld_offset, 3'b000};
        ld_keep    = size_keep(ld_size);
        ld_top     = ld_keep & ~(ld_keep >> 1);
        ld_sign    = ~ld_unsigned & (|(ld_shifted & ld_top));
        ld_data    = (ld_shifted & ld_keep) | (ld_sign ? ~ld_keep : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - handshaked memory-access stage; MISALIGN_TRAP_EN enables misaligned-access trapping
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter  int DataWidth = 32,
    parameter  int AddrWidth = 32,
    localparam int MaskWidth = DataWidth / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 store,
    input  logic [2:0]           fun3,
    input  logic [AddrWidth-1:0] alu_out_address,
    input  logic [DataWidth-1:0] operand_b,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [MaskWidth-1:0] mem_mask,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 data_valid,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 stall,
    output logic                 load_valid,
    output logic [DataWidth-1:0] load_data,
    output logic                 misalign
);
    localparam int OffW = $clog2(MaskWidth);

    mem_state_e state, next_state;

    logic [1:0]           req_size;
    logic [OffW-1:0]      req_offset;
    logic [MaskWidth-1:0] req_mask;
    logic [DataWidth-1:0] req_wdata;
    logic                 req_misaligned;
    logic [1:0]           ld_size;
    logic [OffW-1:0]      ld_offset;
    logic                 ld_unsigned;
    logic [DataWidth-1:0] ld_data_ext;
    logic                 access;
    logic                 trap;
    logic                 accept;
    logic                 done;

    assign access     = load | store;
    assign req_offset = alu_out_address[OffW-1:0];

    // Double-word accesses only exist on a 64-bit bus; narrower buses treat them as words.
    always_comb begin
        req_size = fun3[1:0];
        if (DataWidth < 64 && req_size == SZ_DOUBLE) begin
            req_size = SZ_WORD;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (state == IDLE) & access & req_misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = req_misaligned;
    assign trap = 1'b0;
`endif

    assign accept = (state == IDLE) & access & ~trap;

    mem_lane_align #(
        .DataWidth(DataWidth)
    ) u_align (
        .st_size    (req_size),
        .st_offset  (req_offset),
        .st_data    (operand_b),
        .mask       (req_mask),
        .wdata      (req_wdata),
        .misaligned (req_misaligned),
        .ld_size    (ld_size),
        .ld_offset  (ld_offset),
        .ld_unsigned(ld_unsigned),
        .rdata      (mem_rdata),
        .ld_data    (ld_data_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a store finishes on grant, a load waits for read data.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = REQ;
            REQ:  if (mem_gnt) next_state = mem_we ? IDLE : WAIT;
            WAIT: if (data_valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: stall and load result are combinational so the pipeline moves in the done cycle.
    always_comb begin
        done       = ((state == REQ) & mem_gnt & mem_we) | ((state == WAIT) & data_valid);
        stall      = access & ~done & ~trap;
        load_valid = (state == WAIT) & data_valid;
        load_data  = load_valid ? ld_data_ext : '0;
        misalign   = trap & rst_n;
    end

    // Request registers: captured on acceptance, held until grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_mask    <= '0;
            mem_wdata   <= '0;
            ld_size     <= SZ_BYTE;
            ld_offset   <= '0;
            ld_unsigned <= 1'b0;
        end else if (accept) begin
            mem_req     <= 1'b1;
            mem_we      <= store;
            mem_addr    <= {alu_out_address[AddrWidth-1:OffW], {OffW{1'b0}}};
            mem_mask    <= req_mask;
            mem_wdata   <= req_wdata;
            ld_size     <= req_size;
            ld_offset   <= req_offset;
            ld_unsigned <= fun3[2];
        end else if (state == REQ && mem_gnt) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        store;
    logic [2:0]  fun3;
    logic [31:0] alu_out_address;
    logic [31:0] operand_b;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        data_valid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] ld_q[$];

    mem_access_unit #(
        .DataWidth(32),
        .AddrWidth(32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .store          (store),
        .fun3           (fun3),
        .alu_out_address(alu_out_address),
        .operand_b      (operand_b),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_mask       (mem_mask),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .data_valid     (data_valid),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_access(input string tag, input bit st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b,
                              input int gnt_dly, input int dv_dly, input logic [31:0] rd,
                              input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_ld, input int exp_stall);
        req_t        e;
        int          stalls;
        logic [31:0] exp_data;
        req_q.push_back('{we: st, addr: a & 32'hFFFF_FFFC, mask: exp_mask, wdata: exp_wdata});
        if (!st) ld_q.push_back(exp_ld);
        @(negedge clk);
        load = ~st; store = st; fun3 = f3; alu_out_address = a; operand_b = b;
        #1;
        chk({tag, " idle_req"}, mem_req, 1'b0);
        stalls = int'(stall);
        @(negedge clk);
        e = req_q.pop_front();
        for (int i = 0; i < gnt_dly; i++) begin
            data_valid = 1'b1;
            #1;
            chk({tag, " hold_req"}, mem_req, 1'b1);
            chk({tag, " hold_addr"}, mem_addr, e.addr);
            chk({tag, " hold_mask"}, mem_mask, e.mask);
            chk({tag, " spurious_valid"}, load_valid, 1'b0);
            stalls += int'(stall);
            @(negedge clk);
            data_valid = 1'b0;
        end
        mem_gnt = 1'b1;
        #1;
        chk({tag, " req"}, mem_req, 1'b1);
        chk({tag, " we"}, mem_we, e.we);
        chk({tag, " addr"}, mem_addr, e.addr);
        chk({tag, " mask"}, mem_mask, e.mask);
        if (st) chk({tag, " wdata"}, mem_wdata, e.wdata);
        stalls += int'(stall);
        @(negedge clk);
        mem_gnt = 1'b0;
        if (st) begin
            load = 1'b0; store = 1'b0;
        end else begin
            for (int i = 0; i < dv_dly; i++) begin
                #1;
                chk({tag, " wait_req"}, mem_req, 1'b0);
                chk({tag, " wait_valid"}, load_valid, 1'b0);
                stalls += int'(stall);
                @(negedge clk);
            end
            data_valid = 1'b1; mem_rdata = rd;
            #1;
            exp_data = ld_q.pop_front();
            chk({tag, " load_valid"}, load_valid, 1'b1);
            chk({tag, " load_data"}, load_data, exp_data);
            stalls += int'(stall);
            @(negedge clk);
            data_valid = 1'b0; load = 1'b0;
        end
        #1;
        chk({tag, " valid_after"}, load_valid, 1'b0);
        chk({tag, " stall_cycles"}, stalls, exp_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; store = 1'b0; fun3 = 3'b000;
        alu_out_address = '0; operand_b = '0; mem_gnt = 1'b0;
        data_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_mask", mem_mask, 4'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst load_valid", load_valid, 1'b0);
        chk("rst load_data", load_data, 32'h0);
        chk("rst misalign", misalign, 1'b0);
        chk("rst stall", stall, 1'b0);
        rst_n = 1'b1;

        run_access("sb",  1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 0, 0, 32'h0,
                   4'b1000, 32'hAB00_0000, 32'h0, 1);
        run_access("lh",  1'b0, 3'b001, 32'h2002, 32'h0, 0, 3, 32'h8001_1234,
                   4'b1100, 32'h0, 32'hFFFF_8001, 5);
        run_access("lbu", 1'b0, 3'b100, 32'h2001, 32'h0, 0, 0, 32'h0000_F000,
                   4'b0010, 32'h0, 32'h0000_00F0, 2);
        run_access("lb",  1'b0, 3'b000, 32'h6000, 32'h0, 0, 0, 32'h0000_00FF,
                   4'b0001, 32'h0, 32'hFFFF_FFFF, 2);
        run_access("lhu", 1'b0, 3'b101, 32'h6002, 32'h0, 0, 1, 32'h8001_0000,
                   4'b1100, 32'h0, 32'h0000_8001, 3);
        run_access("lw_gnt_hold", 1'b0, 3'b010, 32'h4004, 32'h0, 4, 0, 32'h1234_5678,
                   4'b1111, 32'h0, 32'h1234_5678, 6);
        run_access("sh",  1'b1, 3'b001, 32'h5002, 32'hFFFF_BEEF, 2, 0, 32'h0,
                   4'b1100, 32'hBEEF_0000, 32'h0, 3);
        run_access("sw",  1'b1, 3'b010, 32'h5004, 32'hDEAD_BEEF, 0, 0, 32'h0,
                   4'b1111, 32'hDEAD_BEEF, 32'h0, 1);

        // Reset while the load waits for read data; later data must be ignored.
        @(negedge clk);
        load = 1'b1; fun3 = 3'b010; alu_out_address = 32'h7000;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("rstwait req", mem_req, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b0; rst_n = 1'b0; load = 1'b0;
        @(negedge clk);
        #1;
        chk("rstwait mem_req", mem_req, 1'b0);
        chk("rstwait mem_addr", mem_addr, 32'h0);
        chk("rstwait mem_mask", mem_mask, 4'h0);
        chk("rstwait mem_wdata", mem_wdata, 32'h0);
        chk("rstwait load_valid", load_valid, 1'b0);
        chk("rstwait load_data", load_data, 32'h0);
        rst_n = 1'b1; data_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rstwait late_valid", load_valid, 1'b0);
        chk("rstwait late_data", load_data, 32'h0);
        @(negedge clk);
        #1;
        chk("rstwait late_valid2", load_valid, 1'b0);
        data_valid = 1'b0;

`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        load = 1'b1; fun3 = 3'b010; alu_out_address = 32'h3002;
        #1;
        chk("trap misalign", misalign, 1'b1);
        chk("trap stall", stall, 1'b0);
        @(negedge clk);
        load = 1'b0;
        #1;
        chk("trap misalign_pulse", misalign, 1'b0);
        chk("trap mem_req", mem_req, 1'b0);
        @(negedge clk);
        #1;
        chk("trap mem_req2", mem_req, 1'b0);
`else
        run_access("lw_misaligned", 1'b0, 3'b010, 32'h3002, 32'h0, 0, 0, 32'hAAAA_5555,
                   4'b1100, 32'h0, 32'h0000_AAAA, 2);
        chk("no_trap misalign", misalign, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
